// File: rtl/hermes_boundary_ejector.sv
// Hermes mesh sink: drops header, filters on EJ_ADDR, queues size+payload flits for a valid/ready host stream.
// Latency 1 cycle flit-to-tvalid; credit_o = !full, misrouted packets are absorbed at full rate.
module hermes_ej_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_vld) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Extra pointer bit distinguishes a full ring from an empty one.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign head_dat = mem[rd_ptr[AW-1:0]];
endmodule

module hermes_boundary_ejector #(
  parameter int          FLIT_SIZE    = 32,
  parameter int          BUFFER_DEPTH = 8,
  parameter logic [15:0] EJ_ADDR      = 16'h0101
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic [FLIT_SIZE-1:0] tdata_o,
  output logic                 tvalid_o,
  input  logic                 tready_i,
  output logic                 tfirst_o,
  output logic                 tlast_o,
  output logic [15:0]          pkt_cnt_o,
  output logic [15:0]          drop_cnt_o
);
  typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD} state_t;

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic [FLIT_SIZE-1:0] dat;
  } entry_t;

  state_t               state, state_nxt;
  logic                 match, match_nxt;
  logic [FLIT_SIZE-1:0] rem, rem_nxt;
  logic [15:0]          pkt_cnt, drop_cnt;
  logic                 push, pkt_inc, drop_inc;
  entry_t               wr_entry, head;
  logic                 fifo_full, fifo_empty, accept, pop;

  assign credit_o = !fifo_full;
  assign accept   = rx_i && credit_o;
  assign tvalid_o = !fifo_empty;
  assign pop      = tvalid_o && tready_i;

  hermes_ej_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(BUFFER_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (push),
    .push_dat (wr_entry),
    .pop_vld  (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head is masked while empty so stale memory never shows on the stream.
  assign tdata_o  = tvalid_o ? head.dat : '0;
  assign tfirst_o = tvalid_o && head.first;
  assign tlast_o  = tvalid_o && head.last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_HEADER;
      match    <= 1'b0;
      rem      <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      match <= match_nxt;
      rem   <= rem_nxt;
      if (pkt_inc && pkt_cnt != 16'hFFFF)   pkt_cnt  <= pkt_cnt + 16'd1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match;
    rem_nxt   = rem;
    push      = 1'b0;
    wr_entry  = '0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    if (accept) begin
      case (state)
        S_HEADER: begin
          match_nxt = (data_i[15:0] == EJ_ADDR);
          state_nxt = S_SIZE;
        end
        S_SIZE: begin
          rem_nxt        = data_i;
          push           = match;
          wr_entry.first = 1'b1;
          wr_entry.last  = (data_i == '0);
          wr_entry.dat   = data_i;
          if (data_i == '0) begin
            state_nxt = S_HEADER;
            pkt_inc   = match;
            drop_inc  = !match;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          push           = match;
          wr_entry.first = 1'b0;
          wr_entry.last  = (rem == FLIT_SIZE'(1));
          wr_entry.dat   = data_i;
          rem_nxt        = rem - FLIT_SIZE'(1);
          if (rem == FLIT_SIZE'(1)) begin
            state_nxt = S_HEADER;
            pkt_inc   = match;
            drop_inc  = !match;
          end
        end
        default: state_nxt = S_HEADER;
      endcase
    end
  end

  assign pkt_cnt_o  = pkt_cnt;
  assign drop_cnt_o = drop_cnt;
endmodule

// File: tb/tb_hermes_boundary_ejector.sv
// Directed bench for hermes_boundary_ejector: routed, misrouted, zero-length, backpressure, full-rate and reset cases.
module tb_hermes_boundary_ejector;
  logic        clk_i;
  logic        rst_ni;
  logic        rx_i;
  logic [31:0] data_i;
  logic        credit_o;
  logic [31:0] tdata_o;
  logic        tvalid_o;
  logic        tready_i;
  logic        tfirst_o;
  logic        tlast_o;
  logic [15:0] pkt_cnt_o;
  logic [15:0] drop_cnt_o;

  int vectors;
  int miscompares;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];

  hermes_boundary_ejector #(
    .FLIT_SIZE(32),
    .BUFFER_DEPTH(8),
    .EJ_ADDR(16'h0101)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .data_i     (data_i),
    .credit_o   (credit_o),
    .tdata_o    (tdata_o),
    .tvalid_o   (tvalid_o),
    .tready_i   (tready_i),
    .tfirst_o   (tfirst_o),
    .tlast_o    (tlast_o),
    .pkt_cnt_o  (pkt_cnt_o),
    .drop_cnt_o (drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Beats are recorded mid-cycle, when a handshake is guaranteed at the next edge.
  always @(negedge clk_i) begin
    if (rst_ni && tvalid_o && tready_i) got_q.push_back({tfirst_o, tlast_o, tdata_o});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask

  task automatic send_flit(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!credit_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (!credit_o) check("credit_wait", credit_o, 1);
    rx_i   = 1'b1;
    data_i = d;
    @(posedge clk_i);
    #1 rx_i = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   idx;
    int   low_cnt;
    int   guard;
    logic acc;
    logic started;

    vectors     = 0;
    miscompares = 0;
    rst_ni      = 1'b0;
    rx_i        = 1'b0;
    data_i      = '0;
    tready_i    = 1'b0;
    wait_cycles(2);

    check("rst_credit", credit_o, 1);
    check("rst_tvalid", tvalid_o, 0);
    check("rst_tfirst", tfirst_o, 0);
    check("rst_tlast",  tlast_o, 0);
    check("rst_tdata",  tdata_o, 0);
    check("rst_pkt",    pkt_cnt_o, 0);
    check("rst_drop",   drop_cnt_o, 0);
    rst_ni = 1'b1;
    wait_cycles(1);

    // Single routed packet, consumer always ready
    tready_i = 1'b1;
    send_flit(32'h0000_0101);
    check("hdr_not_stored", tvalid_o, 0);
    send_flit(32'd3);
    check("size_tvalid", tvalid_o, 1);
    check("size_tdata",  tdata_o, 3);
    check("size_tfirst", tfirst_o, 1);
    send_flit(32'hA1);
    send_flit(32'hA2);
    send_flit(32'hA3);
    wait_cycles(4);
    exp_q.push_back({2'b10, 32'd3});
    exp_q.push_back({2'b00, 32'hA1});
    exp_q.push_back({2'b00, 32'hA2});
    exp_q.push_back({2'b01, 32'hA3});
    compare_stream("single");
    check("single_pkt",  pkt_cnt_o, 1);
    check("single_drop", drop_cnt_o, 0);

    // Misrouted packet is swallowed
    send_flit(32'h0000_0000);
    check("mis_credit_h", credit_o, 1);
    send_flit(32'd2);
    check("mis_credit_s", credit_o, 1);
    check("mis_tvalid_s", tvalid_o, 0);
    send_flit(32'hEE);
    send_flit(32'hFF);
    check("mis_credit_p", credit_o, 1);
    check("mis_tvalid_p", tvalid_o, 0);
    check("mis_drop", drop_cnt_o, 1);
    check("mis_pkt",  pkt_cnt_o, 1);
    wait_cycles(2);
    check("mis_stream_len", got_q.size(), 0);

    // Zero-length packet; also proves the FSM is back in S_HEADER
    send_flit(32'h0000_0101);
    send_flit(32'd0);
    check("zl_tvalid", tvalid_o, 1);
    check("zl_tfirst", tfirst_o, 1);
    check("zl_tlast",  tlast_o, 1);
    wait_cycles(3);
    exp_q.push_back({2'b11, 32'd0});
    compare_stream("zerolen");
    check("zl_pkt", pkt_cnt_o, 2);

    // Backpressure: size 10, FIFO fills after size + 7 payload
    tready_i = 1'b0;
    send_flit(32'h0000_0101);
    send_flit(32'd10);
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("bp_credit_before%0d", i), credit_o, 1);
      send_flit(32'hB0 + i);
    end
    check("bp_credit_full", credit_o, 0);
    for (int i = 8; i <= 10; i++) begin
      tready_i = 1'b1;
      @(posedge clk_i);
      #1 tready_i = 1'b0;
      check($sformatf("bp_credit_rise%0d", i), credit_o, 1);
      send_flit(32'hB0 + i);
      check($sformatf("bp_credit_refull%0d", i), credit_o, 0);
    end
    check("bp_pkt", pkt_cnt_o, 3);
    tready_i = 1'b1;
    wait_cycles(12);
    exp_q.push_back({2'b10, 32'd10});
    for (int i = 1; i <= 10; i++) exp_q.push_back({1'b0, i == 10, 32'hB0 + i});
    compare_stream("backpressure");

    // Fill, then stream with rx and tready both held high
    tready_i = 1'b0;
    send_flit(32'h0000_0101);
    send_flit(32'd20);
    for (int i = 1; i <= 7; i++) send_flit(32'hD0 + i);
    check("ff_credit_full", credit_o, 0);
    tready_i = 1'b1;
    rx_i     = 1'b1;
    idx      = 8;
    data_i   = 32'hD0 + idx;
    low_cnt  = 0;
    started  = 1'b0;
    guard    = 0;
    while (idx <= 20 && guard < 200) begin
      @(negedge clk_i);
      acc = credit_o;
      if (started && !acc) low_cnt++;
      @(posedge clk_i);
      #1;
      if (acc) begin
        started = 1'b1;
        idx++;
        data_i = 32'hD0 + idx;
      end
      guard++;
    end
    rx_i = 1'b0;
    check("ff_all_sent", idx, 21);
    check("ff_credit_steady", low_cnt, 0);
    wait_cycles(12);
    exp_q.push_back({2'b10, 32'd20});
    for (int i = 1; i <= 20; i++) exp_q.push_back({1'b0, i == 20, 32'hD0 + i});
    compare_stream("fullrate");
    check("ff_pkt", pkt_cnt_o, 4);

    // Reset in the middle of a stored packet
    tready_i = 1'b0;
    send_flit(32'h0000_0101);
    send_flit(32'd5);
    send_flit(32'hC1);
    send_flit(32'hC2);
    check("pre_rst_tvalid", tvalid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_tvalid", tvalid_o, 0);
    check("mid_rst_pkt",    pkt_cnt_o, 0);
    check("mid_rst_drop",   drop_cnt_o, 0);
    check("mid_rst_credit", credit_o, 1);
    check("mid_rst_tdata",  tdata_o, 0);
    wait_cycles(1);
    rst_ni = 1'b1;
    got_q.delete();
    tready_i = 1'b1;
    send_flit(32'h0000_0101);
    send_flit(32'd1);
    send_flit(32'hB1);
    wait_cycles(3);
    exp_q.push_back({2'b10, 32'd1});
    exp_q.push_back({2'b01, 32'hB1});
    compare_stream("post_reset");
    check("post_rst_pkt", pkt_cnt_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
